// File: rtl/i2c_bit_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// i2c_bit_ctrl_pkg
//   Shared definitions for the I2C bit engine and the byte-level sequencer
//   that drives it: command codes, quarter-bit phase encodings, the default
//   prescale divisor, the engine state type and the per-phase pin table.
//
//   Contents:
//     CMD_*            3-bit command codes (any other code behaves as NOP)
//     PH_0..PH_3       quarter-bit phase encodings
//     CLK_DIV_DEFAULT  clk cycles per quarter-bit phase
//     state_e          engine state (IDLE / RUN)
//     pins_t           {scl, sda_oe} pin drive pair
//     is_bus_cmd()     true for codes that actually touch the bus
//     phase_pins()     pin levels a command drives in a given phase
// ----------------------------------------------------------------------------
package i2c_bit_ctrl_pkg;

    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_STOP  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b100;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    localparam int CLK_DIV_DEFAULT = 125;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic scl;
        logic sda_oe;
    } pins_t;

    function automatic logic is_bus_cmd(input logic [2:0] c);
        return (c == CMD_START) || (c == CMD_STOP) ||
               (c == CMD_WRITE) || (c == CMD_READ);
    endfunction

    // Pin drive for command c in phase ph. Fields not touched by a command in
    // a given phase keep their previous value (e.g. SCL in START phase 0), so
    // a repeated START from a low SCL only releases SDA first.
    function automatic pins_t phase_pins(input logic [2:0] c,
                                         input logic [1:0] ph,
                                         input logic       d,
                                         input pins_t      prev);
        pins_t p;
        p = prev;
        case (c)
            CMD_START: begin
                case (ph)
                    PH_0:    p.sda_oe = 1'b0;
                    PH_1:    begin p.scl = 1'b1; p.sda_oe = 1'b0; end
                    PH_2:    begin p.scl = 1'b1; p.sda_oe = 1'b1; end
                    default: begin p.scl = 1'b0; p.sda_oe = 1'b1; end
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    PH_0:    begin p.scl = 1'b0; p.sda_oe = 1'b1; end
                    PH_1:    begin p.scl = 1'b1; p.sda_oe = 1'b1; end
                    default: begin p.scl = 1'b1; p.sda_oe = 1'b0; end
                endcase
            end
            CMD_WRITE: begin
                p.sda_oe = ~d;
                p.scl    = (ph == PH_1) || (ph == PH_2);
            end
            CMD_READ: begin
                p.sda_oe = 1'b0;
                p.scl    = (ph == PH_1) || (ph == PH_2);
            end
            default: p = prev;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/i2c_bit_ctrl_prescaler.sv
// ----------------------------------------------------------------------------
// i2c_prescaler
//   Quarter-bit timebase. Counts 0..CLK_DIV-1 while clr is low and pulses
//   tick on the last count. Holding clr keeps the counter at zero so the first
//   tick after clr falls comes exactly CLK_DIV cycles later.
//
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous active-low reset
//     clr   in   hold counter at zero
//     tick  out  high during the last cycle of each quarter-bit phase
// ----------------------------------------------------------------------------
module i2c_prescaler #(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/i2c_bit_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_bit_ctrl
//   Bit-level I2C master engine. Takes one primitive (START, STOP, WRITE bit,
//   READ bit) per handshake, runs it through four quarter-bit phases of
//   CLK_DIV clocks each, and drives SCL (push-pull) and SDA (open drain).
//   Single master: no clock stretching, no arbitration.
//
//   Handshake: a command is taken on any rising clk edge where cmd_valid and
//   cmd_ready are both high; cmd and din are latched there and later changes
//   are ignored. cmd_ready is high only in IDLE; nothing is queued while busy.
//   done pulses for one cycle when a command finishes, and cmd_ready is
//   already high in that cycle so commands can run back to back.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-low reset; releases the bus at once
//     cmd[2:0]   in   command code (see i2c_bit_ctrl_pkg, others are NOP)
//     cmd_valid  in   command present
//     cmd_ready  out  engine idle and able to accept
//     din        in   bit to send for WRITE
//     dout       out  bit captured by the most recent READ
//     done       out  one-cycle completion pulse
//     busy       out  inverse of cmd_ready
//     scl_o      out  SCL level
//     sda_oe     out  1 pulls SDA low, 0 releases it
//     sda_i      in   raw SDA pin level (asynchronous)
// ----------------------------------------------------------------------------
module i2c_bit_ctrl
    import i2c_bit_ctrl_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       din,
    output logic       dout,
    output logic       done,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] cmd_q,   cmd_d;
    logic       din_q,   din_d;
    logic       scl_q,   scl_d;
    logic       oe_q,    oe_d;
    logic       dout_q,  dout_d;
    logic       done_q,  done_d;
    logic [1:0] sync_q;

    logic  sda_s;
    logic  tick;
    logic  pre_clr;
    pins_t cur_pins;
    pins_t nxt_pins;

    // Two-flop synchronizer for the asynchronous SDA pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sda_i};
        end
    end
    assign sda_s = sync_q[1];

    // Counter sits at zero in IDLE, so the accept edge starts phase 0 with a
    // fresh count.
    assign pre_clr = (state_q == ST_IDLE);

    i2c_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign cur_pins = '{scl: scl_q, sda_oe: oe_q};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cmd_d    = cmd_q;
        din_d    = din_q;
        scl_d    = scl_q;
        oe_d     = oe_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        nxt_pins = cur_pins;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd;
                    din_d = din;
                    if (is_bus_cmd(cmd)) begin
                        state_d  = ST_RUN;
                        phase_d  = PH_0;
                        nxt_pins = phase_pins(cmd, PH_0, din, cur_pins);
                        scl_d    = nxt_pins.scl;
                        oe_d     = nxt_pins.sda_oe;
                    end else begin
                        // NOP-like codes complete immediately without
                        // leaving IDLE.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (phase_q == PH_3) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d  = phase_q + 2'd1;
                        nxt_pins = phase_pins(cmd_q, phase_d, din_q, cur_pins);
                        scl_d    = nxt_pins.scl;
                        oe_d     = nxt_pins.sda_oe;
                    end
                    // End of phase 1 is the middle of the SCL-high window.
                    if ((cmd_q == CMD_READ) && (phase_q == PH_1)) begin
                        dout_d = sda_s;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_0;
            cmd_q   <= 3'b000;
            din_q   <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign scl_o     = scl_q;
    assign sda_oe    = oe_q;
    assign dout      = dout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
module tb_i2c_bit_ctrl;

  localparam int D   = 4;
  localparam int BIT = 4 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic       cmd_valid = 1'b0;
  logic       din = 1'b0;
  logic       sda_i = 1'b1;
  logic       cmd_ready, dout, done, busy, scl_o, sda_oe;

  int n_vec = 0;
  int n_err = 0;

  // Reference bus state: pin levels left by the last command and last READ bit.
  logic m_scl  = 1'b1;
  logic m_oe   = 1'b0;
  logic m_dout = 1'b0;

  typedef struct {
    logic [2:0] c;
    logic       d;
    logic       rd;
    logic       hold;
    logic       f_scl;
    logic       f_oe;
    logic       f_dout;
  } vec_t;

  vec_t tab[13];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  i2c_bit_ctrl #(.CLK_DIV(D), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .din       (din),
    .dout      (dout),
    .done      (done),
    .busy      (busy),
    .scl_o     (scl_o),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus-level meaning of each command, per quarter-bit phase.
  // want_scl=1 gives the SCL level, otherwise 1 = SDA released.
  // -1 means "whatever it was before".
  function automatic int level(input logic [2:0] c, input int ph, input bit want_scl, input logic d);
    int s[4];
    int r[4];
    s = '{-1, -1, -1, -1};
    r = '{-1, -1, -1, -1};
    if (c == 3'd1) begin s = '{-1, 1, 1, 0}; r = '{1, 1, 0, 0}; end
    if (c == 3'd2) begin s = '{0, 1, 1, 1};  r = '{0, 0, 1, 1}; end
    if (c == 3'd3) begin s = '{0, 1, 1, 0};  r = d ? '{1, 1, 1, 1} : '{0, 0, 0, 0}; end
    if (c == 3'd4) begin s = '{0, 1, 1, 0};  r = '{1, 1, 1, 1}; end
    return want_scl ? s[ph] : r[ph];
  endfunction

  function automatic logic exp_scl(input logic [2:0] c, input int ph, input logic d);
    int v;
    v = level(c, ph, 1'b1, d);
    return (v < 0) ? m_scl : (v != 0);
  endfunction

  function automatic logic exp_oe(input logic [2:0] c, input int ph, input logic d);
    int v;
    v = level(c, ph, 1'b0, d);
    return (v < 0) ? m_oe : (v == 0);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Presents a command, waits (bounded) for the accept
  // edge, then checks every cycle of the command against the reference and
  // returns at the negedge of the done cycle.
  task automatic issue(input logic [2:0] c, input logic d, input logic rd, input bit hold);
    int   guard;
    bit   bus;
    logic e_dout;
    guard     = 0;
    cmd       = c;
    din       = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    bus = (c >= 3'd1) && (c <= 3'd4);
    if (c == 3'd4) sda_i = ~rd;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs while busy: they must be ignored.
    cmd = 3'($urandom_range(0, 7));
    din = 1'($urandom_range(0, 1));
    if (!hold) cmd_valid = 1'b0;
    if (!bus) begin
      check("nop_done", done, 1'b1);
      check("nop_ready", cmd_ready, 1'b1);
      check("nop_scl", scl_o, m_scl);
      check("nop_oe", sda_oe, m_oe);
      check("nop_dout", dout, m_dout);
      return;
    end
    for (int k = 0; k < BIT; k++) begin
      if (k > 0) @(negedge clk);
      if (c == 3'd4 && k == D)     sda_i = rd;
      if (c == 3'd4 && k == 2 * D) sda_i = ~rd;
      e_dout = (c == 3'd4 && k >= 2 * D) ? rd : m_dout;
      check("run_scl", scl_o, exp_scl(c, k / D, d));
      check("run_oe", sda_oe, exp_oe(c, k / D, d));
      check("run_done", done, 1'b0);
      check("run_ready", cmd_ready, 1'b0);
      check("run_busy", busy, 1'b1);
      check("run_dout", dout, e_dout);
    end
    @(negedge clk);
    m_scl = exp_scl(c, 3, d);
    m_oe  = exp_oe(c, 3, d);
    if (c == 3'd4) m_dout = rd;
    check("end_done", done, 1'b1);
    check("end_ready", cmd_ready, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_scl", scl_o, m_scl);
    check("end_oe", sda_oe, m_oe);
    check("end_dout", dout, m_dout);
  endtask

  // ---------------- test ----------------
  initial begin
    tab[0]  = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[5]  = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[6]  = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[7]  = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[8]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[9]  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[10] = '{3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[11] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[12] = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl", scl_o, 1'b1);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven back-to-back commands
    for (int i = 0; i < 13; i++) begin
      issue(tab[i].c, tab[i].d, tab[i].rd, tab[i].hold);
      check("tab_scl", scl_o, tab[i].f_scl);
      check("tab_oe", sda_oe, tab[i].f_oe);
      check("tab_dout", dout, tab[i].f_dout);
    end

    // Reset in phase 2 of a WRITE 0
    cmd = 3'd3;
    din = 1'b0;
    cmd_valid = 1'b1;
    check("pre_rst_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2 * D) @(negedge clk);
    check("ph2_scl", scl_o, 1'b1);
    check("ph2_oe", sda_oe, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_scl", scl_o, 1'b1);
    check("arst_oe", sda_oe, 1'b0);
    check("arst_ready", cmd_ready, 1'b1);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    m_scl = 1'b1;
    m_oe = 1'b0;
    m_dout = 1'b0;
    for (int k = 0; k < 2 * D; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_scl", scl_o, 1'b1);
    end
    issue(3'd1, 1'b0, 1'b0, 1'b0);

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("final_done", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
